// File: rtl/cache_fill_responder_if.sv
// rtl/cache_fill_responder_if.sv - cache fetch port and memory read bus of the fill responder
interface cache_fill_responder_if;
    logic        address_enable;
    logic [31:0] address;
    logic        data_valid;
    logic [31:0] data;
    logic        error;
    logic        flush;
    logic        mem_read;
    logic [29:0] mem_address;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport slave (
        input  address_enable, address, flush, mem_ack, mem_rdata,
        output data_valid, data, error, mem_read, mem_address
    );

    modport master (
        output address_enable, address, flush, mem_ack, mem_rdata,
        input  data_valid, data, error, mem_read, mem_address
    );
endinterface

// File: rtl/cache_fill_responder.sv
// rtl/cache_fill_responder.sv - cache fetch responder with last-word buffer and bounded bus reads
module cache_fill_responder #(
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] ERROR_WORD = 32'hDEAD_BEEF
) (
    input logic                   clock,
    input logic                   reset_n,
    cache_fill_responder_if.slave bus
);
    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    logic [1:0]    state;
    logic [29:0]   cur_addr;
    logic [29:0]   buf_addr;
    logic [31:0]   buf_data;
    logic          buf_valid;
    logic          resp_err;
    logic [CW-1:0] counter;
    logic          mem_read;
    logic [29:0]   mem_address;

    logic [29:0] word_addr;
    logic        match;
    logic        hit;
    logic        expired;
    logic        unused_low_bits;

    assign word_addr       = bus.address[31:2];
    assign unused_low_bits = ^bus.address[1:0];
    assign match           = (word_addr == cur_addr);
    assign hit             = buf_valid && (word_addr == buf_addr) && !bus.flush;
    assign expired         = (counter == LAST);

    // Gated combinationally so a response never validates an address the cache has moved off.
    assign bus.data_valid  = (state == RESPOND) && bus.address_enable && match;
    assign bus.data        = resp_err ? ERROR_WORD : buf_data;
    assign bus.error       = bus.data_valid && resp_err;
    assign bus.mem_read    = mem_read;
    assign bus.mem_address = mem_address;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cur_addr    <= '0;
            buf_addr    <= '0;
            buf_data    <= '0;
            buf_valid   <= 1'b0;
            resp_err    <= 1'b0;
            counter     <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.address_enable) begin
                        cur_addr <= word_addr;
                        if (hit) begin
                            state    <= RESPOND;
                            resp_err <= 1'b0;
                        end else begin
                            state       <= ISSUE;
                            mem_read    <= 1'b1;
                            mem_address <= word_addr;
                            counter     <= '0;
                        end
                    end
                end
                ISSUE: begin
                    counter <= counter + 1'b1;
                    if (bus.mem_ack) begin
                        buf_data  <= bus.mem_rdata;
                        buf_addr  <= cur_addr;
                        buf_valid <= 1'b1;
                        mem_read  <= 1'b0;
                        resp_err  <= 1'b0;
                        state     <= RESPOND;
                    end else if (expired) begin
                        mem_read <= 1'b0;
                        resp_err <= 1'b1;
                        state    <= RESPOND;
                    end else if (!bus.address_enable || !match) begin
                        // The bus read cannot be cancelled; let it finish with the address held.
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    counter <= counter + 1'b1;
                    if (bus.mem_ack || expired) begin
                        mem_read <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    if (!(bus.address_enable && match)) begin
                        state <= IDLE;
                    end
                end
            endcase
            // Flush wins over a load in the same cycle; the data is still captured.
            if (bus.flush) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cache_fill_responder.sv
// tb/tb_cache_fill_responder.sv - randomized self-checking bench for cache_fill_responder
module tb_cache_fill_responder;
    localparam int          TIMEOUT    = 4;
    localparam logic [31:0] ERROR_WORD = 32'hDEAD_BEEF;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    cache_fill_responder_if bus ();

    cache_fill_responder #(.TIMEOUT(TIMEOUT), .ERROR_WORD(ERROR_WORD)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start(input logic [31:0] a);
        @(negedge clock);
        bus.address_enable = 1'b1;
        bus.address        = a;
    endtask

    task automatic finish_req();
        bus.address_enable = 1'b0;
        @(negedge clock);
    endtask

    // Acts as memory: acks in the delay-th cycle mem_read is seen high; never acks if delay > TIMEOUT.
    task automatic serve(input logic [31:0] a, input int delay, input logic [31:0] rd, input logic flush_on_ack,
                         output int rd_cycles, output int lat, output logic [31:0] d, output logic e,
                         output logic addr_ok);
        lat = 0; rd_cycles = 0; d = 'x; e = 1'bx; addr_ok = 1'b1;
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(negedge clock);
            bus.mem_ack = 1'b0;
            bus.flush   = 1'b0;
            if (bus.data_valid) begin
                lat = c; d = bus.data; e = bus.error;
            end else if (bus.mem_read) begin
                rd_cycles++;
                if (bus.mem_address !== a[31:2]) addr_ok = 1'b0;
                if (rd_cycles == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rd;
                    bus.flush     = flush_on_ack;
                end
            end
        end
        bus.mem_ack = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset();
        bus.address_enable = 1'b0; bus.address = '0; bus.flush = 1'b0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        reset_n = 1'b0;
        @(negedge clock); @(negedge clock);
        vectors++;
        if ({bus.mem_read, bus.data_valid, bus.error} !== 3'b000) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 000", {bus.mem_read, bus.data_valid, bus.error});
        end
        vectors++;
        if (bus.data !== 32'h0 || bus.mem_address !== 30'h0) begin
            miscompares++; $display("FAIL reset_data: got data %h addr %h want 0 0", bus.data, bus.mem_address);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_miss();
        int rc, lat; logic [31:0] d; logic e, ok;
        start(32'h100);
        serve(32'h100, 3, 32'h1234_5678, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 3 || ok !== 1'b1) begin
            miscompares++; $display("FAIL miss_bus: got %0d cycles addr_ok %b want 3 1", rc, ok);
        end
        vectors++;
        if (lat !== 4 || d !== 32'h1234_5678 || e !== 1'b0) begin
            miscompares++; $display("FAIL miss_resp: got lat %0d data %h err %b want 4 12345678 0", lat, d, e);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            vectors++;
            if (bus.data_valid !== 1'b1 || bus.data !== 32'h1234_5678) begin
                miscompares++; $display("FAIL miss_hold: got %b %h want 1 12345678", bus.data_valid, bus.data);
            end
        end
        finish_req();
    endtask

    task automatic test_hit();
        int rc, lat; logic [31:0] d; logic e, ok;
        start(32'h103);
        serve(32'h103, 1, 32'h0BAD_0BAD, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 0 || lat !== 1 || d !== 32'h1234_5678 || e !== 1'b0) begin
            miscompares++; $display("FAIL hit: got rd %0d lat %0d data %h err %b want 0 1 12345678 0", rc, lat, d, e);
        end
        bus.address = 32'h108;
        #1;
        vectors++;
        if (bus.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL addr_change_valid: got %b want 0", bus.data_valid);
        end
        serve(32'h108, 2, 32'hA5A5_0108, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 2 || ok !== 1'b1 || d !== 32'hA5A5_0108) begin
            miscompares++; $display("FAIL addr_change_miss: got rd %0d ok %b data %h want 2 1 a5a50108", rc, ok, d);
        end
        finish_req();
    endtask

    task automatic test_abort();
        int rc, lat; logic [31:0] d; logic e, ok;
        start(32'h200);
        @(negedge clock);
        vectors++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 30'h080 || bus.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL abort_issue: got %b %h %b want 1 080 0", bus.mem_read, bus.mem_address, bus.data_valid);
        end
        bus.address = 32'h300;
        @(negedge clock);
        vectors++;
        if (bus.mem_read !== 1'b1 || bus.mem_address !== 30'h080 || bus.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL abort_drain: got %b %h %b want 1 080 0", bus.mem_read, bus.mem_address, bus.data_valid);
        end
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0;
        serve(32'h300, 2, 32'h0300_CAFE, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 2 || ok !== 1'b1 || d !== 32'h0300_CAFE || e !== 1'b0) begin
            miscompares++; $display("FAIL abort_next: got rd %0d ok %b data %h err %b want 2 1 0300cafe 0", rc, ok, d, e);
        end
        finish_req();
        start(32'h200);
        serve(32'h200, 1, 32'h0200_0200, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 1 || d !== 32'h0200_0200) begin
            miscompares++; $display("FAIL abort_discard: got rd %0d data %h want 1 02000200", rc, d);
        end
        finish_req();
    endtask

    task automatic test_timeout();
        int rc, lat; logic [31:0] d; logic e, ok;
        for (int k = 0; k < 2; k++) begin
            start(32'h400);
            serve(32'h400, 99, 32'h0, 1'b0, rc, lat, d, e, ok);
            vectors++;
            if (rc !== TIMEOUT || lat !== TIMEOUT + 1 || ok !== 1'b1) begin
                miscompares++; $display("FAIL timeout_bus%0d: got rd %0d lat %0d ok %b want %0d %0d 1", k, rc, lat, ok, TIMEOUT, TIMEOUT + 1);
            end
            vectors++;
            if (d !== ERROR_WORD || e !== 1'b1) begin
                miscompares++; $display("FAIL timeout_resp%0d: got %h %b want %h 1", k, d, e, ERROR_WORD);
            end
            finish_req();
        end
    endtask

    task automatic test_flush();
        int rc, lat; logic [31:0] d; logic e, ok;
        start(32'h500);
        serve(32'h500, 1, 32'h0500_0001, 1'b0, rc, lat, d, e, ok);
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (bus.data_valid !== 1'b1 || bus.data !== 32'h0500_0001) begin
                miscompares++; $display("FAIL flush_hold: got %b %h want 1 05000001", bus.data_valid, bus.data);
            end
            @(negedge clock);
        end
        finish_req();
        start(32'h500);
        serve(32'h500, 1, 32'h0500_0002, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 1 || d !== 32'h0500_0002) begin
            miscompares++; $display("FAIL flush_miss: got rd %0d data %h want 1 05000002", rc, d);
        end
        finish_req();
        start(32'h540);
        serve(32'h540, 2, 32'h0540_0001, 1'b1, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 2 || d !== 32'h0540_0001 || e !== 1'b0) begin
            miscompares++; $display("FAIL flush_ack_resp: got rd %0d data %h err %b want 2 05400001 0", rc, d, e);
        end
        finish_req();
        start(32'h540);
        serve(32'h540, 1, 32'h0540_0002, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 1 || d !== 32'h0540_0002) begin
            miscompares++; $display("FAIL flush_ack_miss: got rd %0d data %h want 1 05400002", rc, d);
        end
        finish_req();
    endtask

    task automatic test_reset_mid();
        int rc, lat; logic [31:0] d; logic e, ok;
        start(32'h600);
        serve(32'h600, 1, 32'h0600_0001, 1'b0, rc, lat, d, e, ok);
        finish_req();
        start(32'h700);
        @(negedge clock);
        vectors++;
        if (bus.mem_read !== 1'b1) begin
            miscompares++; $display("FAIL rst_pre: got mem_read %b want 1", bus.mem_read);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.mem_read !== 1'b0 || bus.data_valid !== 1'b0) begin
            miscompares++; $display("FAIL rst_async: got %b %b want 0 0", bus.mem_read, bus.data_valid);
        end
        bus.address_enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        start(32'h600);
        serve(32'h600, 1, 32'h0600_0002, 1'b0, rc, lat, d, e, ok);
        vectors++;
        if (rc !== 1 || d !== 32'h0600_0002) begin
            miscompares++; $display("FAIL rst_miss: got rd %0d data %h want 1 06000002", rc, d);
        end
        finish_req();
    endtask

    task automatic test_random();
        logic        m_valid;
        logic [29:0] m_addr;
        logic [31:0] m_data;
        int rc, lat, delay, exp_rc, exp_lat; logic [31:0] a, rd, d, exp_d; logic e, ok, exp_e;
        bus.flush = 1'b1;
        @(negedge clock);
        bus.flush = 1'b0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        for (int i = 0; i < 60; i++) begin
            a     = 32'h1000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            delay = $urandom_range(1, 6);
            rd    = $urandom;
            if ($urandom_range(0, 4) == 0) begin
                bus.flush = 1'b1;
                @(negedge clock);
                bus.flush = 1'b0;
                m_valid = 1'b0;
            end
            if (m_valid && a[31:2] == m_addr) begin
                exp_rc = 0; exp_lat = 1; exp_d = m_data; exp_e = 1'b0;
            end else if (delay <= TIMEOUT) begin
                exp_rc = delay; exp_lat = delay + 1; exp_d = rd; exp_e = 1'b0;
                m_valid = 1'b1; m_addr = a[31:2]; m_data = rd;
            end else begin
                exp_rc = TIMEOUT; exp_lat = TIMEOUT + 1; exp_d = ERROR_WORD; exp_e = 1'b1;
            end
            start(a);
            serve(a, delay, rd, 1'b0, rc, lat, d, e, ok);
            vectors++;
            if (rc !== exp_rc || lat !== exp_lat || ok !== 1'b1) begin
                miscompares++; $display("FAIL rand%0d_bus: addr %h got rd %0d lat %0d ok %b want %0d %0d 1", i, a, rc, lat, ok, exp_rc, exp_lat);
            end
            vectors++;
            if (d !== exp_d || e !== exp_e) begin
                miscompares++; $display("FAIL rand%0d_resp: addr %h got %h %b want %h %b", i, a, d, e, exp_d, exp_e);
            end
            finish_req();
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_abort();
        test_timeout();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
